clk_div_reconfig_ctrl: RTL and testbench

//  Sequences glitch-free reprogramming of a fractional clock divider: takes 12-bit divider writes from the IO bus,

---
 rtl/clk_div_reconfig_ctrl_pkg.sv | 37 +++
 rtl/clk_div_reconfig_ctrl_if.sv | 20 ++
 rtl/clk_div_reconfig_regs.sv | 78 +++++++
 rtl/clk_div_reconfig_ctrl.sv | 132 +++++++++++++
 tb/tb_clk_div_reconfig_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/clk_div_reconfig_ctrl_pkg.sv
// Shared types and constants for the divider reconfiguration controller:
// FSM state encoding, IO register map, STAT/CTRL bit positions.
package clk_div_pkg;

   localparam int CDivCfgW = 12;
   localparam int CStatW   = 4;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StDrain  = 2'd1,
      StLoad   = 2'd2,
      StSettle = 2'd3
   } divStateT;

   localparam logic [1:0] COffCfg  = 2'd0;
   localparam logic [1:0] COffCtrl = 2'd1;
   localparam logic [1:0] COffStat = 2'd2;

   localparam logic [3:0] CSizeCfg  = 4'd2;
   localparam logic [3:0] CSizeCtrl = 4'd1;
   localparam logic [3:0] CSizeStat = 4'd1;

   localparam int CStatBusy = 0;
   localparam int CStatPend = 1;
   localparam int CStatTmo  = 2;
   localparam int CStatErr  = 3;

   localparam int CCtrlEnable = 0;
   localparam int CCtrlForce  = 1;
   localparam int CCtrlClear  = 2;

   // A zero integer divisor would stall the divider, so such writes are rejected.
   function automatic logic cfgIntLegal(input logic [CDivCfgW-1:0] cfg);
      return |cfg[CDivCfgW-1:4];
   endfunction

endpackage

// File: rtl/clk_div_reconfig_ctrl_if.sv
// IO bus bundle between the bus master and the divider reconfiguration controller.
interface clk_div_reconfig_ctrl_if;
   logic [15:0] AIoAddr;
   logic [63:0] AIoMosi;
   logic [3:0]  AIoWrSize;
   logic [3:0]  AIoRdSize;
   logic [63:0] AIoMiso;
   logic        AIoAddrAck;
   logic        AIoAddrErr;

   modport master (
      output AIoAddr, AIoMosi, AIoWrSize, AIoRdSize,
      input  AIoMiso, AIoAddrAck, AIoAddrErr
   );

   modport slave (
      input  AIoAddr, AIoMosi, AIoWrSize, AIoRdSize,
      output AIoMiso, AIoAddrAck, AIoAddrErr
   );
endinterface

// File: rtl/clk_div_reconfig_regs.sv
// IO decode for the reconfiguration controller: ack/err, CFG shadow and CTRL
// enable capture, CTRL strobes and the combinational STAT read mux.
module clk_div_reconfig_regs
   import clk_div_pkg::*;
#(
   parameter logic [15:0]         CAddrBase = 16'h0000,
   parameter logic [CDivCfgW-1:0] CDivReset = 12'h0A0
) (
   input  logic                   AClkH,
   input  logic                   AResetH,
   clk_div_reconfig_ctrl_if.slave io,
   input  logic [CStatW-1:0]      statBits,
   output logic [CDivCfgW-1:0]    shadowCfg,
   output logic                   enable,
   output logic                   cfgWr,
   output logic                   cfgBad,
   output logic                   forceStb,
   output logic                   clearStb
);
   logic [16:0]         offset;
   logic                inRange;
   logic                access;
   logic                legal;
   logic                selCfg;
   logic                selCtrl;
   logic                selStat;
   logic                ctrlWr;
   logic [CDivCfgW-1:0] shadowReg;
   logic                enableReg;
   logic                unusedMosi;

   always_comb begin
      // 17-bit subtraction so addresses below the base wrap to a large offset.
      offset  = {1'b0, io.AIoAddr} - {1'b0, CAddrBase};
      inRange = (offset < 17'd3);
      selCfg  = inRange && (offset[1:0] == COffCfg);
      selCtrl = inRange && (offset[1:0] == COffCtrl);
      selStat = inRange && (offset[1:0] == COffStat);
      access  = (io.AIoWrSize != 4'd0) || (io.AIoRdSize != 4'd0);
      legal   = (selCfg  && io.AIoWrSize == CSizeCfg  && io.AIoRdSize == 4'd0) ||
                (selCtrl && io.AIoWrSize == CSizeCtrl && io.AIoRdSize == 4'd0) ||
                (selStat && io.AIoRdSize == CSizeStat && io.AIoWrSize == 4'd0);

      io.AIoAddrAck = inRange && access && legal;
      io.AIoAddrErr = inRange && access && !legal;

      cfgWr    = selCfg && legal && cfgIntLegal(io.AIoMosi[CDivCfgW-1:0]);
      cfgBad   = selCfg && legal && !cfgIntLegal(io.AIoMosi[CDivCfgW-1:0]);
      ctrlWr   = selCtrl && legal;
      forceStb = ctrlWr && io.AIoMosi[CCtrlForce];
      clearStb = ctrlWr && io.AIoMosi[CCtrlClear];

      io.AIoMiso = '0;
      if (selStat && legal) begin
         io.AIoMiso[CStatW-1:0] = statBits;
      end
   end

   assign unusedMosi = ^io.AIoMosi[63:CDivCfgW];

   always_ff @(posedge AClkH) begin
      if (AResetH) begin
         shadowReg <= CDivReset;
         enableReg <= 1'b1;
      end else begin
         if (cfgWr) begin
            shadowReg <= io.AIoMosi[CDivCfgW-1:0];
         end
         if (ctrlWr) begin
            enableReg <= io.AIoMosi[CCtrlEnable];
         end
      end
   end

   assign shadowCfg = shadowReg;
   assign enable    = enableReg;

endmodule

// File: rtl/clk_div_reconfig_ctrl.sv
// Glitch-free fractional divider reprogramming: shadow -> drain to period boundary
// -> load -> settle. CLK_DIV_RECONFIG_GATE_EN masks clock enables during switchover.
module clk_div_reconfig_ctrl
   import clk_div_pkg::*;
#(
   parameter logic [15:0]         CAddrBase     = 16'h0000,
   parameter logic [CDivCfgW-1:0] CDivReset     = 12'h0A0,
   parameter int                  CDrainTmoW    = 10,
   parameter logic [7:0]          CSettleCycles = 8'd16
) (
   input  logic                   AClkH,
   input  logic                   AResetH,
   clk_div_reconfig_ctrl_if.slave io,
   input  logic                   ADivTerm,
   input  logic                   AClkEnI,
   output logic [CDivCfgW-1:0]    ADivCfg,
   output logic                   ADivLoad,
   output logic                   AClkEnO,
   output logic                   ABusy
);
   localparam logic [CDrainTmoW-1:0] CTmoMax = '1;

   divStateT              stateReg, stateNext;
   logic [CDrainTmoW-1:0] tmoCntReg, tmoCntNext;
   logic [7:0]            settleCntReg, settleCntNext;
   logic [CDivCfgW-1:0]   divCfgReg, divCfgNext;
   logic                  pendingReg, pendingNext;
   logic                  tmoFlagReg, tmoFlagNext;
   logic                  errFlagReg, errFlagNext;
   logic                  tmoSet;
   logic                  busy;
   logic [CDivCfgW-1:0]   shadowCfg;
   logic                  enable, cfgWr, cfgBad, forceStb, clearStb;
   logic [CStatW-1:0]     statBits;

   assign busy     = (stateReg != StIdle);
   assign statBits = {errFlagReg, tmoFlagReg, pendingReg, busy};

   clk_div_reconfig_regs #(
      .CAddrBase (CAddrBase),
      .CDivReset (CDivReset)
   ) uRegs (
      .AClkH     (AClkH),
      .AResetH   (AResetH),
      .io        (io),
      .statBits  (statBits),
      .shadowCfg (shadowCfg),
      .enable    (enable),
      .cfgWr     (cfgWr),
      .cfgBad    (cfgBad),
      .forceStb  (forceStb),
      .clearStb  (clearStb)
   );

   always_ff @(posedge AClkH) begin
      if (AResetH) begin
         stateReg     <= StIdle;
         tmoCntReg    <= '0;
         settleCntReg <= '0;
         divCfgReg    <= CDivReset;
         pendingReg   <= 1'b0;
         tmoFlagReg   <= 1'b0;
         errFlagReg   <= 1'b0;
      end else begin
         stateReg     <= stateNext;
         tmoCntReg    <= tmoCntNext;
         settleCntReg <= settleCntNext;
         divCfgReg    <= divCfgNext;
         pendingReg   <= pendingNext;
         tmoFlagReg   <= tmoFlagNext;
         errFlagReg   <= errFlagNext;
      end
   end

   always_comb begin
      stateNext = stateReg;
      tmoSet    = 1'b0;
      case (stateReg)
         StIdle: begin
            // A CFG write this cycle counts as pending so DRAIN starts next cycle.
            if ((pendingReg || cfgWr) && enable) begin
               stateNext = forceStb ? StLoad : StDrain;
            end
         end
         StDrain: begin
            if (ADivTerm || forceStb) begin
               stateNext = StLoad;
            end else if (tmoCntReg == CTmoMax) begin
               stateNext = StLoad;
               tmoSet    = 1'b1;
            end else if (!enable) begin
               stateNext = StIdle;
            end
         end
         StLoad:   stateNext = StSettle;
         StSettle: if (settleCntReg == 8'd0) stateNext = StIdle;
         default:  stateNext = StIdle;
      endcase

      // Counter holds the number of DRAIN cycles so far, so all-ones means 2**W-1 cycles.
      tmoCntNext = tmoCntReg;
      if (stateReg == StDrain) begin
         tmoCntNext = tmoCntReg + 1'b1;
      end else if (stateNext == StDrain) begin
         tmoCntNext = CDrainTmoW'(1);
      end

      settleCntNext = settleCntReg;
      if (stateReg == StLoad) begin
         settleCntNext = CSettleCycles - 8'd1;
      end else if (stateReg == StSettle && settleCntReg != 8'd0) begin
         settleCntNext = settleCntReg - 8'd1;
      end

      divCfgNext  = (stateReg == StLoad) ? shadowCfg : divCfgReg;
      pendingNext = cfgWr ? 1'b1 : ((stateReg == StLoad) ? 1'b0 : pendingReg);
      tmoFlagNext = tmoSet ? 1'b1 : (clearStb ? 1'b0 : tmoFlagReg);
      errFlagNext = cfgBad ? 1'b1 : (clearStb ? 1'b0 : errFlagReg);
   end

   always_comb begin
      ADivCfg  = divCfgReg;
      ADivLoad = (stateReg == StLoad);
      ABusy    = busy;
`ifdef CLK_DIV_RECONFIG_GATE_EN
      AClkEnO  = AClkEnI & ~((stateReg == StLoad) | (stateReg == StSettle));
`else
      AClkEnO  = AClkEnI;
`endif
   end

endmodule

// File: tb/tb_clk_div_reconfig_ctrl.sv
// Scoreboard bench for clk_div_reconfig_ctrl: stimulus pushes expected bus responses
// and load events; a negedge monitor pops and compares them against the DUT.
module tb_clk_div_reconfig_ctrl;
   import clk_div_pkg::*;

   localparam int CSettle    = 16;
   localparam int CTmoCycles = 1023;

   logic        AClkH = 1'b0;
   logic        AResetH = 1'b1;
   logic        ADivTerm = 1'b0;
   logic        AClkEnI = 1'b1;
   logic [11:0] ADivCfg;
   logic        ADivLoad;
   logic        AClkEnO;
   logic        ABusy;

   int nTests = 0;
   int nFail  = 0;
   int cyc    = 0;
   logic monEn = 1'b0;

   clk_div_reconfig_ctrl_if io ();

   clk_div_reconfig_ctrl #(
      .CAddrBase     (16'h0000),
      .CDivReset     (12'h0A0),
      .CDrainTmoW    (10),
      .CSettleCycles (8'd16)
   ) dut (
      .AClkH    (AClkH),
      .AResetH  (AResetH),
      .io       (io),
      .ADivTerm (ADivTerm),
      .AClkEnI  (AClkEnI),
      .ADivCfg  (ADivCfg),
      .ADivLoad (ADivLoad),
      .AClkEnO  (AClkEnO),
      .ABusy    (ABusy)
   );

   always #5 AClkH = ~AClkH;
   always @(posedge AClkH) cyc <= cyc + 1;

   typedef struct { string name; logic ack; logic err; logic [63:0] miso; } busExpT;
   typedef struct { int cyc; logic [11:0] cfg; } loadExpT;
   busExpT  busQ[$];
   loadExpT loadQ[$];

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      nTests++;
      if (act !== exp) begin
         nFail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // ---------------- monitor ----------------
   busExpT  be;
   loadExpT le;
   int      cfgChkCyc = -1;
   logic [11:0] cfgChkVal = '0;
   int      busyHiCyc = -1;
   int      busyLoCyc = -1;
   int      gateLo = -100;
   int      gateHi = -100;
   logic    expEn;

   always @(negedge AClkH) begin
      if (monEn) begin
         if (io.AIoWrSize != 4'd0 || io.AIoRdSize != 4'd0) begin
            if (busQ.size() == 0) begin
               chk("bus_unexpected", 64'(io.AIoAddrAck), 64'(1'b0));
            end else begin
               be = busQ.pop_front();
               $display("[TB] cyc %0d bus %s addr=%h wr=%0d rd=%0d ack=%b err=%b miso=%h",
                        cyc, be.name, io.AIoAddr, io.AIoWrSize, io.AIoRdSize,
                        io.AIoAddrAck, io.AIoAddrErr, io.AIoMiso);
               chk({be.name, "_ack"}, 64'(io.AIoAddrAck), 64'(be.ack));
               chk({be.name, "_err"}, 64'(io.AIoAddrErr), 64'(be.err));
               chk({be.name, "_miso"}, io.AIoMiso, be.miso);
            end
         end else begin
            chk("miso_idle", io.AIoMiso, 64'd0);
         end

         if (loadQ.size() != 0 && loadQ[0].cyc == cyc) begin
            le = loadQ.pop_front();
            $display("[TB] cyc %0d load expected cfg=%h pulse=%b", cyc, le.cfg, ADivLoad);
            chk("load_pulse", 64'(ADivLoad), 64'(1'b1));
            cfgChkCyc = le.cyc + 1;
            cfgChkVal = le.cfg;
            busyHiCyc = le.cyc + CSettle;
            busyLoCyc = le.cyc + CSettle + 1;
            gateLo    = le.cyc;
            gateHi    = le.cyc + CSettle;
         end else begin
            chk("no_load", 64'(ADivLoad), 64'(1'b0));
         end

         if (cyc == cfgChkCyc) chk("cfg_applied", 64'(ADivCfg), 64'(cfgChkVal));
         if (cyc == busyHiCyc) chk("busy_settle", 64'(ABusy), 64'(1'b1));
         if (cyc == busyLoCyc) chk("busy_idle", 64'(ABusy), 64'(1'b0));

`ifdef CLK_DIV_RECONFIG_GATE_EN
         expEn = AClkEnI & ~(cyc >= gateLo && cyc <= gateHi);
`else
         expEn = AClkEnI;
`endif
         chk("clk_en", 64'(AClkEnO), 64'(expEn));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge AClkH);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic busOp(input string name, input logic [15:0] addr, input logic [3:0] wr,
                        input logic [3:0] rd, input logic [63:0] data, input logic expAck,
                        input logic expErr, input logic [63:0] expMiso);
      busExpT e;
      e.name = name; e.ack = expAck; e.err = expErr; e.miso = expMiso;
      busQ.push_back(e);
      io.AIoAddr = addr; io.AIoMosi = data; io.AIoWrSize = wr; io.AIoRdSize = rd;
      tick();
      io.AIoWrSize = 4'd0; io.AIoRdSize = 4'd0;
      io.AIoAddr = 16'($urandom); io.AIoMosi = {$urandom, $urandom};
   endtask

   task automatic statRead(input logic [7:0] exp);
      busOp("stat", 16'h0002, 4'd0, 4'd1, 64'($urandom), 1'b1, 1'b0, {56'd0, exp});
   endtask

   task automatic cfgWrite(input logic [11:0] v);
      busOp("cfg_wr", 16'h0000, 4'd2, 4'd0, {44'd0, 4'($urandom), 4'd0, v}, 1'b1, 1'b0, 64'd0);
   endtask

   task automatic ctrlWrite(input logic [7:0] v);
      busOp("ctrl_wr", 16'h0001, 4'd1, 4'd0, {56'd0, v}, 1'b1, 1'b0, 64'd0);
   endtask

   task automatic pushLoad(input int c, input logic [11:0] v);
      loadExpT e;
      e.cyc = c; e.cfg = v;
      loadQ.push_back(e);
   endtask

   task automatic pulseTerm();
      ADivTerm = 1'b1;
      tick();
      ADivTerm = 1'b0;
   endtask

   function automatic logic [11:0] randLegal();
      logic [11:0] v;
      v = 12'($urandom);
      if (v[11:4] == 8'h00) v[11:4] = 8'h01;
      return v;
   endfunction

   initial begin
      forever begin
         @(posedge AClkH);
         #1;
         AClkEnI = 1'($urandom_range(0, 1));
      end
   end

   // ---------------- scenarios ----------------
   int t, k;
   logic [11:0] v, a, b, cfgM;

   initial begin
      io.AIoAddr = 16'h0; io.AIoMosi = 64'h0; io.AIoWrSize = 4'd0; io.AIoRdSize = 4'd0;
      cfgM = 12'h0A0;

      repeat (2) @(posedge AClkH);
      #1;
      AResetH = 1'b0;
      monEn   = 1'b1;
      @(negedge AClkH);
      chk("rst_cfg", 64'(ADivCfg), 64'(cfgM));
      chk("rst_busy", 64'(ABusy), 64'(1'b0));
      tick();
      statRead(8'h00);

      // Normal sequences, drained either by a terminal pulse or a forced load.
      for (int n = 0; n < 6; n++) begin
         v = randLegal();
         k = $urandom_range(2, 8);
         if (n == 0) begin v = 12'h153; k = 5; end
         t = cyc;
         cfgWrite(v);
         statRead(8'h03);
         idle(k - 2);
         pushLoad(t + k + 1, v);
         if (n == 0 || $urandom_range(0, 1) == 1) pulseTerm();
         else ctrlWrite(8'h03);
         cfgM = v;
         idle(CSettle + 3);
         statRead(8'h00);
      end

      // Drain timeout.
      v = 12'h202;
      t = cyc;
      pushLoad(t + 1 + CTmoCycles, v);
      cfgWrite(v);
      idle(CTmoCycles + CSettle + 4);
      cfgM = v;
      statRead(8'h04);
      ctrlWrite(8'h05);
      statRead(8'h00);

      // Illegal accesses: zero integer divisor, bad sizes, out-of-range addresses.
      cfgWrite(12'h00F);
      statRead(8'h08);
      idle(4);
      cfgWrite({8'h00, 4'($urandom)});
      busOp("cfg_wr4", 16'h0000, 4'd4, 4'd0, 64'h1FF, 1'b0, 1'b1, 64'd0);
      busOp("cfg_rd", 16'h0000, 4'd0, 4'd1, 64'h0, 1'b0, 1'b1, 64'd0);
      for (int n = 0; n < 4; n++) begin
         busOp("ctrl_badsz", 16'h0001, 4'($urandom_range(2, 8)), 4'd0, 64'h0, 1'b0, 1'b1, 64'd0);
         busOp("stat_badsz", 16'h0002, 4'd0, 4'($urandom_range(2, 8)), 64'h0, 1'b0, 1'b1, 64'd0);
         busOp("out_of_range", 16'($urandom_range(3, 65535)), 4'd0, 4'd1, 64'h0, 1'b0, 1'b0, 64'd0);
         busOp("out_of_range_wr", 16'($urandom_range(3, 65535)), 4'd2, 4'd0, 64'h0155, 1'b0, 1'b0, 64'd0);
      end
      @(negedge AClkH);
      chk("illegal_cfg_kept", 64'(ADivCfg), 64'(cfgM));
      tick();
      statRead(8'h08);
      ctrlWrite(8'h05);
      statRead(8'h00);

      // Overlap: second write during DRAIN replaces the first, single load.
      t = cyc;
      cfgWrite(12'h120);
      statRead(8'h03);
      cfgWrite(12'h130);
      idle(2);
      pushLoad(t + 6, 12'h130);
      pulseTerm();
      cfgM = 12'h130;
      idle(CSettle + 3);
      statRead(8'h00);

      // CFG write in the LOAD cycle: stays pending, applied after SETTLE.
      a = randLegal();
      b = randLegal();
      t = cyc;
      cfgWrite(a);
      idle(2);
      pushLoad(t + 4, a);
      pulseTerm();
      cfgWrite(b);
      idle(16);
      statRead(8'h02);
      idle(2);
      pushLoad(t + 25, b);
      pulseTerm();
      cfgM = b;
      idle(CSettle + 3);
      statRead(8'h00);

      // Enable dropped during DRAIN keeps Pending; re-enable then force.
      v = randLegal();
      t = cyc;
      cfgWrite(v);
      ctrlWrite(8'h00);
      idle(2);
      statRead(8'h02);
      pulseTerm();
      ctrlWrite(8'h01);
      idle(1);
      statRead(8'h03);
      pushLoad(t + 10, v);
      ctrlWrite(8'h03);
      cfgM = v;
      idle(CSettle + 3);
      statRead(8'h00);

      // Reset mid-sequence abandons it without a load.
      cfgWrite(randLegal());
      idle(3);
      AResetH = 1'b1;
      idle(2);
      AResetH = 1'b0;
      cfgM = 12'h0A0;
      @(negedge AClkH);
      chk("midrst_cfg", 64'(ADivCfg), 64'(cfgM));
      chk("midrst_busy", 64'(ABusy), 64'(1'b0));
      tick();
      pulseTerm();
      statRead(8'h00);
      idle(5);

      chk("load_queue_empty", 64'(loadQ.size()), 64'd0);
      chk("bus_queue_empty", 64'(busQ.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule
